// File: rtl/fgc_move_guard_if.sv
// rtl/fgc_move_guard_if.sv - request/response, move and bank feedback bundle for fgc_move_guard
interface fgc_move_guard_if #(
    parameter int CNT_W = 8
) ();
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_item_i;
    logic             bank_f_i;
    logic             bank_g_i;
    logic             bank_c_i;
    logic             bank_m_i;
    logic             move_valid_o;
    logic [1:0]       item_o;
    logic             resp_valid_o;
    logic [1:0]       resp_code_o;
    logic [CNT_W-1:0] move_cnt_o;
    logic             solved_o;

    modport slave (
        input  req_valid_i, req_item_i, bank_f_i, bank_g_i, bank_c_i, bank_m_i,
        output req_ready_o, move_valid_o, item_o, resp_valid_o, resp_code_o,
               move_cnt_o, solved_o
    );

    modport master (
        output req_valid_i, req_item_i, bank_f_i, bank_g_i, bank_c_i, bank_m_i,
        input  req_ready_o, move_valid_o, item_o, resp_valid_o, resp_code_o,
               move_cnt_o, solved_o
    );
endinterface

// File: rtl/fgc_move_guard.sv
// rtl/fgc_move_guard.sv - move-legality front end for the fox/goat/cabbage core
module fgc_move_guard #(
    parameter int CNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    fgc_move_guard_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       item_q, item_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       last_item_q, last_item_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             solved_q;

    logic             ready_c, move_valid_c, resp_valid_c;
    logic             all_ones, off_bank, unsafe;
    logic             nf, ng, nc, nm;
    logic [1:0]       check_code;

    // Legality of the registered item against the live banks, used only in CHECK
    always_comb begin
        all_ones = bus.bank_f_i & bus.bank_g_i & bus.bank_c_i & bus.bank_m_i;
        case (item_q)
            2'd1:    off_bank = (bus.bank_f_i != bus.bank_m_i);
            2'd2:    off_bank = (bus.bank_g_i != bus.bank_m_i);
            2'd3:    off_bank = (bus.bank_c_i != bus.bank_m_i);
            default: off_bank = 1'b0;
        endcase
        nm = ~bus.bank_m_i;
        nf = bus.bank_f_i ^ (item_q == 2'd1);
        ng = bus.bank_g_i ^ (item_q == 2'd2);
        nc = bus.bank_c_i ^ (item_q == 2'd3);
        unsafe = ((nf == ng) && (nm != nf)) || ((ng == nc) && (nm != ng));
        if (all_ones)      check_code = 2'd3;
        else if (off_bank) check_code = 2'd1;
        else if (unsafe)   check_code = 2'd2;
        else               check_code = 2'd0;
    end

    always_comb begin
        state_d      = state_q;
        item_d       = item_q;
        code_d       = code_q;
        last_item_d  = last_item_q;
        cnt_d        = cnt_q;
        ready_c      = 1'b0;
        move_valid_c = 1'b0;
        resp_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid_i) begin
                    item_d  = bus.req_item_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                code_d  = check_code;
                state_d = RESP;
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (code_q == 2'd0) begin
                    move_valid_c = 1'b1;
                    last_item_d  = item_q;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            item_q      <= 2'd0;
            code_q      <= 2'd0;
            last_item_q <= 2'd0;
            cnt_q       <= '0;
            solved_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            code_q      <= code_d;
            last_item_q <= last_item_d;
            cnt_q       <= cnt_d;
            solved_q    <= all_ones;
        end
    end

    // item_o shows the live item only on the strobe cycle, otherwise the last issued one
    assign bus.req_ready_o  = ready_c;
    assign bus.move_valid_o = move_valid_c;
    assign bus.item_o       = move_valid_c ? item_q : last_item_q;
    assign bus.resp_valid_o = resp_valid_c;
    assign bus.resp_code_o  = code_q;
    assign bus.move_cnt_o   = cnt_q;
    assign bus.solved_o     = solved_q;
endmodule

// File: tb/tb_fgc_move_guard.sv
// tb/tb_fgc_move_guard.sv - directed bench for fgc_move_guard with a behavioural fgc bank model
module tb_fgc_move_guard;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fgc_move_guard_if #(.CNT_W(8)) g1 ();
    fgc_move_guard_if #(.CNT_W(2)) g2 ();

    fgc_move_guard #(.CNT_W(8)) dut1 (.clk_i(clk), .rstn_i(rstn), .bus(g1));
    fgc_move_guard #(.CNT_W(2)) dut2 (.clk_i(clk), .rstn_i(rstn), .bus(g2));

    logic       v1 = 1'b0, v2 = 1'b0;
    logic [1:0] i1 = 2'd0, i2 = 2'd0;
    logic [3:0] b1, b2; // {m, c, g, f}

    assign g1.req_valid_i = v1;
    assign g1.req_item_i  = i1;
    assign g2.req_valid_i = v2;
    assign g2.req_item_i  = i2;
    assign {g1.bank_m_i, g1.bank_c_i, g1.bank_g_i, g1.bank_f_i} = b1;
    assign {g2.bank_m_i, g2.bank_c_i, g2.bank_g_i, g2.bank_f_i} = b2;

    // Puzzle core: farmer always crosses, the named item crosses with him
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b1 <= 4'b0000;
            b2 <= 4'b0000;
        end else begin
            if (g1.move_valid_o) b1 <= b1 ^ (4'b1000 | ((g1.item_o == 2'd0) ? 4'b0000 : (4'b0001 << (g1.item_o - 2'd1))));
            if (g2.move_valid_o) b2 <= b2 ^ (4'b1000 | ((g2.item_o == 2'd0) ? 4'b0000 : (4'b0001 << (g2.item_o - 2'd1))));
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input bit sel, input int what);
        case (what)
            0: return sel ? 32'(g2.req_ready_o)  : 32'(g1.req_ready_o);
            1: return sel ? 32'(g2.resp_valid_o) : 32'(g1.resp_valid_o);
            2: return sel ? 32'(g2.resp_code_o)  : 32'(g1.resp_code_o);
            3: return sel ? 32'(g2.move_valid_o) : 32'(g1.move_valid_o);
            4: return sel ? 32'(g2.item_o)       : 32'(g1.item_o);
            5: return sel ? 32'(g2.move_cnt_o)   : 32'(g1.move_cnt_o);
            default: return sel ? 32'(g2.solved_o) : 32'(g1.solved_o);
        endcase
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Called and returns on a falling edge; checks N+1..N+4 of one request
    task automatic req_check(input bit sel, input logic [1:0] item, input logic [1:0] e_code,
                             input logic e_mv, input logic [1:0] e_item, input int e_cnt,
                             input logic e_sol, input int idx);
        int waited = 0;
        while (rd(sel, 0) !== 32'd1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("v%0d ready_wait", idx), rd(sel, 0), 32'd1);
        if (sel) begin v2 = 1'b1; i2 = item; end else begin v1 = 1'b1; i1 = item; end
        @(negedge clk);
        chk($sformatf("v%0d ready_check", idx), rd(sel, 0), 32'd0);
        chk($sformatf("v%0d rv_check", idx), rd(sel, 1), 32'd0);
        if (sel) v2 = 1'b0; else v1 = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d resp_valid", idx), rd(sel, 1), 32'd1);
        chk($sformatf("v%0d resp_code", idx), rd(sel, 2), 32'(e_code));
        chk($sformatf("v%0d move_valid", idx), rd(sel, 3), 32'(e_mv));
        chk($sformatf("v%0d item", idx), rd(sel, 4), 32'(e_item));
        @(negedge clk);
        chk($sformatf("v%0d move_cnt", idx), rd(sel, 5), 32'(e_cnt));
        chk($sformatf("v%0d ready_after", idx), rd(sel, 0), 32'd1);
        chk($sformatf("v%0d mv_after", idx), rd(sel, 3), 32'd0);
        chk($sformatf("v%0d item_hold", idx), rd(sel, 4), 32'(e_item));
        @(negedge clk);
        chk($sformatf("v%0d solved", idx), rd(sel, 6), 32'(e_sol));
    endtask

    typedef struct {
        bit         sel;
        bit         rst;
        logic [1:0] item;
        logic [1:0] code;
        logic       mv;
        logic [1:0] item_o;
        int         cnt;
        logic       solved;
    } vec_t;

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{0, 1, 2'd2, 2'd0, 1, 2'd2, 1, 0};
        vecs[1]  = '{0, 1, 2'd1, 2'd2, 0, 2'd0, 0, 0};
        vecs[2]  = '{0, 1, 2'd0, 2'd2, 0, 2'd0, 0, 0};
        vecs[3]  = '{0, 1, 2'd2, 2'd0, 1, 2'd2, 1, 0};
        vecs[4]  = '{0, 0, 2'd1, 2'd1, 0, 2'd2, 1, 0};
        vecs[5]  = '{0, 0, 2'd0, 2'd0, 1, 2'd0, 2, 0};
        vecs[6]  = '{0, 1, 2'd2, 2'd0, 1, 2'd2, 1, 0};
        vecs[7]  = '{0, 0, 2'd0, 2'd0, 1, 2'd0, 2, 0};
        vecs[8]  = '{0, 0, 2'd1, 2'd0, 1, 2'd1, 3, 0};
        vecs[9]  = '{0, 0, 2'd2, 2'd0, 1, 2'd2, 4, 0};
        vecs[10] = '{0, 0, 2'd3, 2'd0, 1, 2'd3, 5, 0};
        vecs[11] = '{0, 0, 2'd0, 2'd0, 1, 2'd0, 6, 0};
        vecs[12] = '{0, 0, 2'd2, 2'd0, 1, 2'd2, 7, 1};
        vecs[13] = '{0, 0, 2'd1, 2'd3, 0, 2'd2, 7, 1};
        vecs[14] = '{0, 0, 2'd0, 2'd3, 0, 2'd2, 7, 1};
        vecs[15] = '{1, 1, 2'd2, 2'd0, 1, 2'd2, 1, 0};
        vecs[16] = '{1, 0, 2'd2, 2'd0, 1, 2'd2, 2, 0};
        vecs[17] = '{1, 0, 2'd2, 2'd0, 1, 2'd2, 3, 0};
        vecs[18] = '{1, 0, 2'd2, 2'd0, 1, 2'd2, 3, 0};
        vecs[19] = '{1, 0, 2'd2, 2'd0, 1, 2'd2, 3, 0};

        @(negedge clk);
        chk("rst move_valid", 32'(g1.move_valid_o), 32'd0);
        chk("rst resp_valid", 32'(g1.resp_valid_o), 32'd0);
        chk("rst resp_code", 32'(g1.resp_code_o), 32'd0);
        chk("rst item", 32'(g1.item_o), 32'd0);
        chk("rst cnt", 32'(g1.move_cnt_o), 32'd0);
        chk("rst solved", 32'(g1.solved_o), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst ready", 32'(g1.req_ready_o), 32'd1);

        for (int k = 0; k < 20; k++) begin
            if (vecs[k].rst) do_reset();
            req_check(vecs[k].sel, vecs[k].item, vecs[k].code, vecs[k].mv,
                      vecs[k].item_o, vecs[k].cnt, vecs[k].solved, k);
        end

        // Request held valid across CHECK/RESP: accepted exactly twice in 7 cycles
        do_reset();
        v1 = 1'b1;
        i1 = 2'd2;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("hold rv c%0d", c), 32'(g1.resp_valid_o), 32'(c == 2 || c == 5));
            chk($sformatf("hold ready c%0d", c), 32'(g1.req_ready_o), 32'(c == 3 || c >= 6));
            if (c == 4) v1 = 1'b0;
        end
        chk("hold cnt", 32'(g1.move_cnt_o), 32'd2);
        chk("hold banks", 32'(b1), 32'd0);

        // Reset landing in the CHECK cycle of a legal request
        do_reset();
        req_check(0, 2'd2, 2'd0, 1, 2'd2, 1, 0, 100);
        v1 = 1'b1;
        i1 = 2'd0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        v1 = 1'b0;
        #1;
        chk("midrst mv", 32'(g1.move_valid_o), 32'd0);
        chk("midrst rv", 32'(g1.resp_valid_o), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("midrst mv hold", 32'(g1.move_valid_o), 32'd0);
            chk("midrst rv hold", 32'(g1.resp_valid_o), 32'd0);
            chk("midrst code", 32'(g1.resp_code_o), 32'd0);
            chk("midrst item", 32'(g1.item_o), 32'd0);
            chk("midrst cnt", 32'(g1.move_cnt_o), 32'd0);
            chk("midrst solved", 32'(g1.solved_o), 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst ready", 32'(g1.req_ready_o), 32'd1);
        chk("midrst rv after", 32'(g1.resp_valid_o), 32'd0);
        @(negedge clk);
        chk("midrst rv after2", 32'(g1.resp_valid_o), 32'd0);
        chk("midrst mv after2", 32'(g1.move_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
